// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: bus widths, ALU op/class codes,
// divider FSM state encodings.
package ex_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'b100;
  localparam logic [ALUSEL_W-1:0] EXE_RES_DIV   = 3'b101;

  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [ALUOP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [ALUOP_W-1:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [ALUOP_W-1:0] EXE_REM_OP  = 8'b1001_1010;
  localparam logic [ALUOP_W-1:0] EXE_REMU_OP = 8'b1001_1011;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_ON   = 2'b01;
  localparam logic [1:0] DIV_ZERO = 2'b10;
  localparam logic [1:0] DIV_END  = 2'b11;

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute bundle in, writeback bundle and stall request out.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [ALUOP_W-1:0]  aluop_i;
  logic [ALUSEL_W-1:0] alusel_i;
  logic [DATA_W-1:0]   reg1_i;
  logic [DATA_W-1:0]   reg2_i;
  logic [ADDR_W-1:0]   wd_i;
  logic                wreg_i;
  logic                annul_i;
  logic [ADDR_W-1:0]   wd_o;
  logic                wreg_o;
  logic [DATA_W-1:0]   wdata_o;
  logic                ovf_o;
  logic                stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i,
    output wd_i, wreg_i, annul_i,
    input  wd_o, wreg_o, wdata_o, ovf_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i,
    input  wd_i, wreg_i, annul_i,
    output wd_o, wreg_o, wdata_o, ovf_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage_div_iter.sv
// Iterative 32-step restoring divider; signed ops divide magnitudes and
// sign-correct the quotient/remainder on the way out.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              annul_i,
  input  logic              signed_i,
  input  logic              rem_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic              rem_sel_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  logic [1:0]          state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic                rem_q, rem_d;

  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   part, diff;

  always_comb begin
    a_mag = (signed_i && a_i[DATA_W-1]) ? -a_i : a_i;
    b_mag = (signed_i && b_i[DATA_W-1]) ? -b_i : b_i;
    // remainder < divisor, so one extra bit holds the shifted partial
    part  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    diff  = part - {1'b0, dvsr_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    rem_d   = rem_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          acc_d   = {{DATA_W{1'b0}}, a_mag};
          dvsr_d  = b_mag;
          negq_d  = signed_i & (a_i[DATA_W-1] ^ b_i[DATA_W-1])
                    & (b_i != '0);
          negr_d  = signed_i & a_i[DATA_W-1];
          rem_d   = rem_i;
          cnt_d   = '0;
          state_d = (b_i == '0) ? DIV_ZERO : DIV_ON;
        end
      end
      DIV_ON: begin
        if (!diff[DATA_W])
          acc_d = {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        else
          acc_d = {part[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DIV_END;
      end
      DIV_ZERO: begin
        acc_d   = {acc_q[DATA_W-1:0], {DATA_W{1'b1}}};
        state_d = DIV_END;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (annul_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      rem_q   <= rem_d;
    end
  end

  logic [DATA_W-1:0] q_raw, r_raw;

  always_comb begin
    q_raw          = acc_q[DATA_W-1:0];
    r_raw          = acc_q[2*DATA_W-1:DATA_W];
    quotient_o     = negq_q ? -q_raw : q_raw;
    remainder_o    = negr_q ? -r_raw : r_raw;
    busy_o         = (state_q == DIV_ON) || (state_q == DIV_ZERO);
    result_valid_o = (state_q == DIV_END);
    rem_sel_o      = rem_q;
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith ALU plus an iterative
// divider that holds the pipe through stallreq_o.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ex_stage_if.slave ex
);

  logic [DATA_W-1:0] a, b, sum, dif;
  logic [4:0]        sh;
  logic [DATA_W-1:0] alu_res;
  logic              add_ovf;
  logic              is_div, sgn, rem;

  logic              div_busy, div_valid, div_rem;
  logic [DATA_W-1:0] div_quo, div_rmd;

  always_comb begin
    a      = ex.reg1_i;
    b      = ex.reg2_i;
    sh     = ex.reg2_i[4:0];
    sum    = a + b;
    dif    = a - b;
    is_div = (ex.alusel_i == EXE_RES_DIV);
    sgn    = (ex.aluop_i == EXE_DIV_OP) || (ex.aluop_i == EXE_REM_OP);
    rem    = (ex.aluop_i == EXE_REM_OP) || (ex.aluop_i == EXE_REMU_OP);
  end

  div_iter u_div (
    .clk            (clk),
    .rst            (rst),
    .start_i        (is_div),
    .annul_i        (ex.annul_i),
    .signed_i       (sgn),
    .rem_i          (rem),
    .a_i            (a),
    .b_i            (b),
    .busy_o         (div_busy),
    .result_valid_o (div_valid),
    .rem_sel_o      (div_rem),
    .quotient_o     (div_quo),
    .remainder_o    (div_rmd)
  );

  always_comb begin
    alu_res = '0;
    add_ovf = 1'b0;
    unique case (1'b1)
      (ex.alusel_i == EXE_RES_LOGIC): begin
        case (ex.aluop_i)
          EXE_AND_OP: alu_res = a & b;
          EXE_OR_OP:  alu_res = a | b;
          EXE_XOR_OP: alu_res = a ^ b;
          EXE_NOR_OP: alu_res = ~(a | b);
          default:    alu_res = '0;
        endcase
      end
      (ex.alusel_i == EXE_RES_SHIFT): begin
        case (ex.aluop_i)
          EXE_SLL_OP: alu_res = a << sh;
          EXE_SRL_OP: alu_res = a >> sh;
          EXE_SRA_OP: alu_res = $unsigned($signed(a) >>> sh);
          default:    alu_res = '0;
        endcase
      end
      (ex.alusel_i == EXE_RES_ARITH): begin
        case (ex.aluop_i)
          EXE_ADD_OP: begin
            alu_res = sum;
            add_ovf = (a[31] ~^ b[31]) & (sum[31] ^ a[31]);
          end
          EXE_ADDU_OP: alu_res = sum;
          EXE_SUB_OP: begin
            alu_res = dif;
            add_ovf = (a[31] ^ b[31]) & (dif[31] ^ a[31]);
          end
          EXE_SUBU_OP: alu_res = dif;
          EXE_SLT_OP:  alu_res = {31'b0, $signed(a) < $signed(b)};
          EXE_SLTU_OP: alu_res = {31'b0, a < b};
          default:     alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    ex.wd_o       = ex.wd_i;
    ex.wreg_o     = ex.wreg_i;
    ex.wdata_o    = '0;
    ex.ovf_o      = 1'b0;
    ex.stallreq_o = 1'b0;
    // once the divider leaves IDLE it owns the outputs until DIV_END
    if (div_busy || div_valid || is_div) begin
      ex.wreg_o     = div_valid & ex.wreg_i;
      ex.wdata_o    = !div_valid ? '0 : (div_rem ? div_rmd : div_quo);
      ex.stallreq_o = ~div_valid;
    end else begin
      ex.wdata_o = alu_res;
      ex.ovf_o   = add_ovf;
      ex.wreg_o  = ex.wreg_i & ~add_ovf;
    end
    if (rst || ex.annul_i) begin
      ex.wd_o       = '0;
      ex.wreg_o     = 1'b0;
      ex.wdata_o    = '0;
      ex.ovf_o      = 1'b0;
      ex.stallreq_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, overflow, divider latency,
// divide-by-zero, back-to-back divides, annul and reset aborts.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ex_stage_if vif ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (vif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    vif.aluop_i  = op;
    vif.alusel_i = sel;
    vif.reg1_i   = a;
    vif.reg2_i   = b;
    vif.wd_i     = 5'd3;
    vif.wreg_i   = 1'b1;
  endtask

  task automatic alu(input string tag, input logic [7:0] op,
                     input logic [2:0] sel, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp,
                     input logic ewreg, input logic eovf);
    @(negedge clk);
    drive(op, sel, a, b);
    #1;
    chk({tag, "_wdata"}, vif.wdata_o, exp);
    chk({tag, "_wreg"}, {31'b0, vif.wreg_o}, {31'b0, ewreg});
    chk({tag, "_ovf"}, {31'b0, vif.ovf_o}, {31'b0, eovf});
    chk({tag, "_stall"}, {31'b0, vif.stallreq_o}, 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
    int wr;
    wr = 0;
    @(negedge clk);
    drive(op, EXE_RES_DIV, a, b);
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (vif.wreg_o) wr++;
      if (c == 0)
        chk({tag, "_stall0"}, {31'b0, vif.stallreq_o}, 32'd1);
      if (c == lat - 1)
        chk({tag, "_stall_last"}, {31'b0, vif.stallreq_o}, 32'd1);
      if (c == lat) begin
        chk({tag, "_stall_end"}, {31'b0, vif.stallreq_o}, 32'd0);
        chk({tag, "_wdata"}, vif.wdata_o, exp);
        chk({tag, "_wd"}, {27'b0, vif.wd_o}, 32'd3);
        chk({tag, "_ovf"}, {31'b0, vif.ovf_o}, 32'd0);
      end
    end
    chk({tag, "_writes"}, wr, 32'd1);
  endtask

  task automatic abort_div(input string tag, input int at, input bit use_rst);
    @(negedge clk);
    drive(EXE_DIV_OP, EXE_RES_DIV, 32'd9, 32'd3);
    for (int c = 1; c <= at; c++) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else vif.annul_i = 1'b1;
    #1;
    chk({tag, "_wreg"}, {31'b0, vif.wreg_o}, 32'd0);
    chk({tag, "_wdata"}, vif.wdata_o, 32'd0);
    chk({tag, "_stall"}, {31'b0, vif.stallreq_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vif.annul_i = 1'b0;
    drive(EXE_ADDU_OP, EXE_RES_ARITH, 32'd2, 32'd3);
    #1;
    chk({tag, "_idle_wdata"}, vif.wdata_o, 32'd5);
    chk({tag, "_idle_stall"}, {31'b0, vif.stallreq_o}, 32'd0);
  endtask

  initial begin
    int wr;
    vif.annul_i = 1'b0;
    drive(EXE_ADDU_OP, EXE_RES_ARITH, 32'd1, 32'd2);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wreg", {31'b0, vif.wreg_o}, 32'd0);
    chk("rst_wdata", vif.wdata_o, 32'd0);
    chk("rst_stall", {31'b0, vif.stallreq_o}, 32'd0);
    chk("rst_wd", {27'b0, vif.wd_o}, 32'd0);
    rst = 1'b0;

    alu("add_ovf", EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'd1,
        32'h8000_0000, 1'b0, 1'b1);
    alu("addu", EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'd1,
        32'h8000_0000, 1'b1, 1'b0);
    alu("add_ok", EXE_ADD_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd2,
        32'd1, 1'b1, 1'b0);
    alu("sub_ovf", EXE_SUB_OP, EXE_RES_ARITH, 32'h8000_0000, 32'd1,
        32'h7FFF_FFFF, 1'b0, 1'b1);
    alu("subu", EXE_SUBU_OP, EXE_RES_ARITH, 32'd0, 32'd1,
        32'hFFFF_FFFF, 1'b1, 1'b0);
    alu("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'h8000_0000, 32'd4,
        32'hF800_0000, 1'b1, 1'b0);
    alu("srl", EXE_SRL_OP, EXE_RES_SHIFT, 32'h8000_0000, 32'd4,
        32'h0800_0000, 1'b1, 1'b0);
    alu("sll", EXE_SLL_OP, EXE_RES_SHIFT, 32'd1, 32'h0000_003F,
        32'h8000_0000, 1'b1, 1'b0);
    alu("sltu", EXE_SLTU_OP, EXE_RES_ARITH, 32'd1, 32'hFFFF_FFFF,
        32'd1, 1'b1, 1'b0);
    alu("slt", EXE_SLT_OP, EXE_RES_ARITH, 32'd1, 32'hFFFF_FFFF,
        32'd0, 1'b1, 1'b0);
    alu("and", EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234, 32'h0FF0_FF00,
        32'h00F0_1200, 1'b1, 1'b0);
    alu("or", EXE_OR_OP, EXE_RES_LOGIC, 32'hF000_0001, 32'h0000_0F00,
        32'hF000_0F01, 1'b1, 1'b0);
    alu("xor", EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'hFF00_FF00,
        32'h00FF_FF00, 1'b1, 1'b0);
    alu("nor", EXE_NOR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0000_00FF,
        32'h0000_FF00, 1'b1, 1'b0);
    alu("unk_logic", EXE_ADD_OP, EXE_RES_LOGIC, 32'd5, 32'd6,
        32'd0, 1'b1, 1'b0);

    run_div("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_div("rem_neg", EXE_REM_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_div("divu", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 33);
    run_div("remu", EXE_REMU_OP, 32'hFFFF_FFFF, 32'd10, 32'd5, 33);
    run_div("divu_z", EXE_DIVU_OP, 32'd100, 32'd0, 32'hFFFF_FFFF, 2);
    run_div("remu_z", EXE_REMU_OP, 32'd100, 32'd0, 32'd100, 2);
    run_div("div_min", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 33);
    run_div("rem_min", EXE_REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    wr = 0;
    @(negedge clk);
    drive(EXE_DIVU_OP, EXE_RES_DIV, 32'd100, 32'd7);
    for (int c = 0; c <= 67; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (vif.wreg_o) wr++;
      if (c == 33) chk("b2b_first", vif.wdata_o, 32'd14);
      if (c == 34)
        chk("b2b_restart", {31'b0, vif.stallreq_o}, 32'd1);
      if (c == 67) begin
        chk("b2b_second", vif.wdata_o, 32'd14);
        chk("b2b_wreg", {31'b0, vif.wreg_o}, 32'd1);
      end
    end
    chk("b2b_writes", wr, 32'd2);

    abort_div("annul", 10, 1'b0);
    run_div("post_annul", EXE_DIV_OP, 32'd9, 32'd3, 32'd3, 33);
    abort_div("rst_mid", 5, 1'b1);
    run_div("post_rst", EXE_REM_OP, 32'd9, 32'hFFFF_FFFC, 32'd1, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
